// File: rtl/l1_pkg.sv
// Shared L1 geometry, refill FSM state encoding and address helpers
// used by the L1I lookup, refill and memory-wrapper blocks.
package l1_pkg;

  localparam int L1_ADDR_WIDTH     = 32;
  localparam int L1_LINE_BYTES     = 32;
  localparam int L1_MEM_DATA_WIDTH = 32;
  localparam int L1_IDX_WIDTH      = 6;
  localparam int L1_WAY_NUM        = 4;
  localparam int L1_OFFS_WIDTH     = $clog2(L1_LINE_BYTES);
  localparam int L1_TAG_WIDTH      = L1_ADDR_WIDTH - L1_IDX_WIDTH - L1_OFFS_WIDTH;
  localparam int L1_WAY_WIDTH      = $clog2(L1_WAY_NUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_t;

  function automatic logic [L1_ADDR_WIDTH-1:0] line_align(input logic [L1_ADDR_WIDTH-1:0] addr);
    line_align = {addr[L1_ADDR_WIDTH-1:L1_OFFS_WIDTH], {L1_OFFS_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/l1_line_buf.sv
// Beat-assembly register: BEATS slots of DATA_WIDTH bits, written one slot
// at a time by index, clearable in one cycle, presented as one flat line.
module l1_line_buf #(
  parameter int BEATS      = 8,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(BEATS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        wen,
  input  logic [IDX_W-1:0]            widx,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [BEATS*DATA_WIDTH-1:0] line
);

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      logic [DATA_WIDTH-1:0] beat_q, beat_d;

      always_comb begin
        beat_d = beat_q;
        if (clr) begin
          beat_d = '0;
        end else if (wen && (widx == IDX_W'(gi))) begin
          beat_d = wdata;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          beat_q <= '0;
        end else begin
          beat_q <= beat_d;
        end
      end

      assign line[gi*DATA_WIDTH +: DATA_WIDTH] = beat_q;
    end
  endgenerate

endmodule

// File: rtl/l1i_refill_ctrl.sv
// L1I miss/refill controller: one line-aligned memory read per miss, beats
// assembled in order, then a single-cycle tag + data write to the victim way.
module l1i_refill_ctrl
  import l1_pkg::*;
#(
  parameter int  ADDR_WIDTH     = L1_ADDR_WIDTH,
  parameter int  LINE_BYTES     = L1_LINE_BYTES,
  parameter int  MEM_DATA_WIDTH = L1_MEM_DATA_WIDTH,
  parameter int  IDX_WIDTH      = L1_IDX_WIDTH,
  parameter int  WAY_NUM        = L1_WAY_NUM,
  localparam int OFFS_WIDTH     = $clog2(LINE_BYTES),
  localparam int TAG_WIDTH      = ADDR_WIDTH - IDX_WIDTH - OFFS_WIDTH,
  localparam int LINE_WIDTH     = LINE_BYTES * 8,
  localparam int WAY_W          = $clog2(WAY_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      miss_val,
  input  logic [ADDR_WIDTH-1:0]     miss_addr,
  input  logic [WAY_W-1:0]          miss_way,
  output logic                      refill_busy,
  output logic                      refill_done,
  output logic                      mem_req_val,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic                      mem_req_ack,
  input  logic                      mem_ack_val,
  input  logic [MEM_DATA_WIDTH-1:0] mem_ack_data,
  output logic [WAY_NUM-1:0]        ld_wen,
  output logic [IDX_WIDTH-1:0]      ld_waddr,
  output logic [TAG_WIDTH:0]        ld_wdata,
  output logic [WAY_NUM-1:0]        dm_wen,
  output logic [IDX_WIDTH-1:0]      dm_waddr,
  output logic [LINE_WIDTH-1:0]     dm_wdata
);

  localparam int BEATS = LINE_WIDTH / MEM_DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int LA_W  = ADDR_WIDTH - OFFS_WIDTH;

  refill_state_t         state_q, state_d;
  logic [LA_W-1:0]       line_addr_q, line_addr_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  buf_clr, buf_wen;
  logic [LINE_WIDTH-1:0] line;

  // Byte offset within the line never matters: requests are line-aligned.
  logic unused_offs;
  assign unused_offs = ^miss_addr[OFFS_WIDTH-1:0];

  l1_line_buf #(
    .BEATS      (BEATS),
    .DATA_WIDTH (MEM_DATA_WIDTH)
  ) u_line_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (buf_clr),
    .wen   (buf_wen),
    .widx  (beat_cnt_q),
    .wdata (mem_ack_data),
    .line  (line)
  );

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    way_d        = way_q;
    beat_cnt_d   = beat_cnt_q;
    buf_clr      = 1'b0;
    buf_wen      = 1'b0;
    refill_busy  = (state_q != IDLE);
    refill_done  = 1'b0;
    mem_req_val  = 1'b0;
    mem_req_addr = '0;
    ld_wen       = '0;
    ld_waddr     = '0;
    ld_wdata     = '0;
    dm_wen       = '0;
    dm_waddr     = '0;
    dm_wdata     = '0;

    case (state_q)
      IDLE: begin
        if (miss_val) begin
          line_addr_d = miss_addr[ADDR_WIDTH-1:OFFS_WIDTH];
          way_d       = miss_way;
          buf_clr     = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        mem_req_val  = 1'b1;
        mem_req_addr = {line_addr_q, {OFFS_WIDTH{1'b0}}};
        if (mem_req_ack) begin
          beat_cnt_d = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_ack_val) begin
          buf_wen    = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        refill_done = 1'b1;
        ld_wen      = WAY_NUM'(1) << way_q;
        dm_wen      = WAY_NUM'(1) << way_q;
        ld_waddr    = line_addr_q[IDX_WIDTH-1:0];
        dm_waddr    = line_addr_q[IDX_WIDTH-1:0];
        ld_wdata    = {1'b1, line_addr_q[LA_W-1:IDX_WIDTH]};
        dm_wdata    = line;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      way_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      way_q       <= way_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule
